// File: rtl/fft_bus_pkg.sv
// +----------------------------------------------------------------------------+
// | fft_bus_pkg : shared types and defaults for the FFT SRAM bus arbiter. Rev 1.0|
// +----------------------------------------------------------------------------+
`default_nettype none

package fft_bus_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting after 'last'.  Rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import fft_bus_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    // Offsets 1..NREQ visit every requester once, ending on 'last' itself.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/avalon_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | avalon_port_arbiter : round-robin sharing of one Avalon-MM master.  Rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module avalon_port_arbiter
  import fft_bus_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_address,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   timeout_flag,
  output logic                   master_read,
  output logic                   master_write,
  output logic [ADDR_W-1:0]      master_address,
  output logic [DATA_W-1:0]      master_write_data,
  input  logic                   master_waitrequest,
  input  logic [DATA_W-1:0]      master_readdata,
  input  logic                   master_readdatavalid,
  input  logic [1:0]             master_response
);

  localparam int         IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d, owner_q, owner_d;
  logic              master_read_q, master_read_d, master_write_q, master_write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d, timeout_q, timeout_d;
  logic [7:0]        wd_q, wd_d;
  logic              done;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_address[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    owner_d        = owner_q;
    master_read_d  = master_read_q;
    master_write_d = master_write_q;
    address_d      = address_q;
    wdata_d        = wdata_q;
    rsp_valid_d    = '0;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    timeout_d      = timeout_q;
    wd_d           = wd_q;
    done           = 1'b0;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (grant_any) begin
          owner_d        = grant_idx;
          last_d         = grant_idx;
          master_write_d = req_write[grant_idx];
          master_read_d  = !req_write[grant_idx];
          address_d      = addr_arr[grant_idx];
          wdata_d        = wdata_arr[grant_idx];
          state_d        = CMD;
        end
      end
      CMD: begin
        if (!master_waitrequest) begin
          if (master_write_q) begin
            done        = 1'b1;
            rsp_err_d   = (master_response != RESP_OKAY);
            rsp_rdata_d = '0;
          end else if (master_readdatavalid) begin
            done        = 1'b1;
            rsp_err_d   = (master_response != RESP_OKAY);
            rsp_rdata_d = master_readdata;
          end else begin
            master_read_d = 1'b0;
            state_d       = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        if (master_readdatavalid) begin
          done        = 1'b1;
          rsp_err_d   = (master_response != RESP_OKAY);
          rsp_rdata_d = master_readdata;
        end
      end
      default: state_d = IDLE;
    endcase

    // A completion in the watchdog's last cycle takes priority over the abort.
    if (state_q != IDLE) begin
      if (done || (wd_q == WD_LAST)) begin
        master_read_d         = 1'b0;
        master_write_d        = 1'b0;
        rsp_valid_d[owner_q]  = 1'b1;
        state_d               = IDLE;
        wd_d                  = '0;
        if (!done) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          timeout_d   = 1'b1;
        end
      end else begin
        wd_d = wd_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      last_q         <= IDX_W'(NREQ - 1);
      owner_q        <= '0;
      master_read_q  <= 1'b0;
      master_write_q <= 1'b0;
      address_q      <= '0;
      wdata_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      timeout_q      <= 1'b0;
      wd_q           <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      owner_q        <= owner_d;
      master_read_q  <= master_read_d;
      master_write_q <= master_write_d;
      address_q      <= address_d;
      wdata_q        <= wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      timeout_q      <= timeout_d;
      wd_q           <= wd_d;
    end
  end

  assign req_ready         = (n_rst && (state_q == IDLE)) ? grant : '0;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_err           = rsp_err_q;
  assign timeout_flag      = timeout_q;
  assign master_read       = master_read_q;
  assign master_write      = master_write_q;
  assign master_address    = address_q;
  assign master_write_data = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_avalon_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_avalon_port_arbiter : directed bench with response scoreboard.   Rev 1.0 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_avalon_port_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [17:0] req_address;
  logic [31:0] req_wdata;
  logic [15:0] rsp_rdata, master_write_data, master_readdata;
  logic        rsp_err, timeout_flag, master_read, master_write;
  logic [8:0]  master_address;
  logic        master_waitrequest, master_readdatavalid;
  logic [1:0]  master_response;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] rdata;
    logic        err;
    bit          chk_data;
    int          due;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_port_arbiter #(
    .NREQ(2), .ADDR_W(9), .DATA_W(16), .TIMEOUT(8)
  ) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .req_valid            (req_valid),
    .req_write            (req_write),
    .req_address          (req_address),
    .req_wdata            (req_wdata),
    .req_ready            (req_ready),
    .rsp_valid            (rsp_valid),
    .rsp_rdata            (rsp_rdata),
    .rsp_err              (rsp_err),
    .timeout_flag         (timeout_flag),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_address       (master_address),
    .master_write_data    (master_write_data),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_response      (master_response)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [15:0] d, input logic e,
                      input bit cd, input int due);
    exp_t x;
    x.valid = v; x.rdata = d; x.err = e; x.chk_data = cd; x.due = due;
    sbq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (n_rst && (|rsp_valid)) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got valid=%b err=%b rdata=%h expected no response",
                 rsp_valid, rsp_err, rsp_rdata);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (rsp_valid !== e.valid || rsp_err !== e.err ||
            (e.chk_data && rsp_rdata !== e.rdata) || cyc != e.due) begin
          failures++;
          $display("FAIL rsp_compare: got valid=%b err=%b rdata=%h cyc=%0d expected valid=%b err=%b rdata=%h cyc=%0d",
                   rsp_valid, rsp_err, rsp_rdata, cyc, e.valid, e.err, e.rdata, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_rst = 1'b0; req_valid = '0; req_write = '0; req_address = '0; req_wdata = '0;
    master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
    master_response = 2'b00;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // Reset mid-CMD
    step();
    req_valid = 2'b01; req_write = 2'b01; req_address = {9'h0, 9'h055};
    req_wdata = {16'h0, 16'hABCD}; master_waitrequest = 1'b1;
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("t1_cmd_active", {master_write, master_address}, {1'b1, 9'h055});
    #1 n_rst = 1'b0;
    req_valid = 2'b11; req_write = 2'b11;
    req_address = {9'h122, 9'h011}; req_wdata = {16'h2222, 16'h1111};
    master_waitrequest = 1'b0;
    #1;
    check("t1_reset_outputs",
          {req_ready, rsp_valid, rsp_rdata, rsp_err, timeout_flag, master_read, master_write,
           master_address, master_write_data}, 64'h0);
    step();
    step();
    n_rst = 1'b1;

    // Round robin over held writes, starting from requester 0
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      check("t2_grant", req_ready, g);
      push(g, 16'h0, 1'b0, 1'b0, cyc + 2);
      step();
      @(negedge clk);
      check("t2_cmd", {master_write, master_address, master_write_data},
            (g == 2'b01) ? {1'b1, 9'h011, 16'h1111} : {1'b1, 9'h122, 16'h2222});
      if (i == 3) req_valid = 2'b00;
      step();
    end
    step();

    // Stalled read with late readdatavalid
    req_valid = 2'b10; req_write = 2'b00; req_address = {9'h1A5, 9'h000};
    master_waitrequest = 1'b1;
    @(negedge clk);
    check("t3_grant", req_ready, 2'b10);
    push(2'b10, 16'hBEEF, 1'b0, 1'b1, cyc + 7);
    step();
    req_valid = 2'b00;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      master_waitrequest   = (j < 3);
      master_readdatavalid = (j == 0);
      master_readdata      = (j == 0) ? 16'hDEAD : 16'h0000;
      @(negedge clk);
      check("t3_addr_stable", {master_read, master_address}, {1'b1, 9'h1A5});
    end
    step();
    master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    @(negedge clk);
    check("t3_read_dropped", master_read, 1'b0);
    step();
    master_readdatavalid = 1'b1; master_readdata = 16'hBEEF;
    step();
    master_readdatavalid = 1'b0; master_readdata = 16'h0000;
    step();

    // Zero-latency read
    req_valid = 2'b01; req_write = 2'b00; req_address = {9'h000, 9'h033};
    @(negedge clk);
    check("t4_grant", req_ready, 2'b01);
    push(2'b01, 16'h0F0F, 1'b0, 1'b1, cyc + 2);
    step();
    req_valid = 2'b00; master_readdatavalid = 1'b1; master_readdata = 16'h0F0F;
    step();
    master_readdatavalid = 1'b0; master_readdata = 16'h0000;
    @(negedge clk);
    check("t4_read_dropped", master_read, 1'b0);
    step();

    // Error response on a write
    req_valid = 2'b10; req_write = 2'b10; req_address = {9'h0AA, 9'h000};
    req_wdata = {16'h5A5A, 16'h0000}; master_response = 2'b10;
    @(negedge clk);
    check("t5_grant", req_ready, 2'b10);
    push(2'b10, 16'h0, 1'b1, 1'b0, cyc + 2);
    step();
    req_valid = 2'b00;
    step();
    master_response = 2'b00;
    @(negedge clk);
    check("t5_no_timeout_flag", timeout_flag, 1'b0);
    step();

    // Watchdog abort on a stuck write
    req_valid = 2'b01; req_write = 2'b01; req_address = {9'h000, 9'h0F0};
    master_waitrequest = 1'b1;
    @(negedge clk);
    check("t6_grant", req_ready, 2'b01);
    push(2'b01, 16'h0, 1'b1, 1'b1, cyc + 9);
    step();
    req_valid = 2'b00;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check("t6_hold", master_write, 1'b1);
      step();
    end
    @(negedge clk);
    check("t6_abort", {master_write, timeout_flag}, 2'b01);
    master_waitrequest = 1'b0;
    step();
    req_valid = 2'b10; req_write = 2'b10;
    @(negedge clk);
    check("t6_next_grant", req_ready, 2'b10);
    push(2'b10, 16'h0, 1'b0, 1'b0, cyc + 2);
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    check("t6_flag_sticky", timeout_flag, 1'b1);

    repeat (3) step();
    check("sb_drained", 64'(sbq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
